instr_fetch_queue: RTL and testbench

//   Producer end of the decoder's instruction interface: fetches 32-bit words from instruction memory,

---
 rtl/instr_fetch_queue.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch front end feeding the decode stage. Issues word-aligned reads to
//   instruction memory, keeps the returned words with their addresses in an
//   in-order FIFO and presents the head as {ins_o, ins_pc_o} with a
//   valid/ready handshake. A redirect flushes the FIFO, restarts fetch at
//   the new address and drops every response still owed by memory.
//
// Ports
//   clk_i              clock, all state on the rising edge
//   rst_i              synchronous active-high reset
//   imem_req_valid_o   fetch request valid
//   imem_req_addr_o    fetch word address ([1:0] always 00)
//   imem_req_ready_i   memory accepts the request this cycle
//   imem_resp_valid_i  read data valid (in request order, latency >= 1)
//   imem_resp_data_i   instruction word
//   redirect_i         flush and restart fetch (one-cycle pulse)
//   redirect_pc_i      restart address ([1:0] ignored)
//   ins_valid_o        head entry valid
//   ins_o              head instruction, 0 when ins_valid_o is low
//   ins_pc_o           address of head instruction
//   ins_ready_i        decode accepts the head entry
//
// State | meaning
//   RUN   | fetching, responses are pushed into the FIFO
//   DRAIN | waiting for responses issued before a redirect; all are dropped

module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ins_valid_o,
  output logic [31:0] ins_o,
  output logic [31:0] ins_pc_o,
  input  logic        ins_ready_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {S_RUN, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] stale_q, stale_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];

  logic             req_fire, push, pop, drop;
  logic [CNT_W:0]   inflight;
  logic [31:0]      redirect_pc_aligned;
  logic             unused_redirect_lsb;

  assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Entries held plus words still owed by memory; bounding this sum by DEPTH
  // guarantees every accepted response has a FIFO slot waiting for it.
  assign inflight = {1'b0, count_q} + {1'b0, outst_q};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    stale_d    = stale_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    imem_req_valid_o = !rst_i && (state_q == S_RUN) && !redirect_i &&
                       (inflight < (CNT_W+1)'(DEPTH));
    imem_req_addr_o  = fetch_pc_q;
    req_fire         = imem_req_valid_o && imem_req_ready_i;

    ins_valid_o = (count_q != '0);
    ins_o       = ins_valid_o ? data_q[rd_ptr_q] : 32'h0;
    // When empty, show the address the next pushed word will carry.
    ins_pc_o    = ins_valid_o ? pc_q[rd_ptr_q] : resp_pc_q;
    pop         = ins_valid_o && ins_ready_i;

    // A response arriving together with a redirect belongs to the old path.
    drop = imem_resp_valid_i && (redirect_i || (stale_q != '0));
    push = imem_resp_valid_i && !drop;

    outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid_i);
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (imem_resp_valid_i && (stale_q != '0)) stale_d = stale_q - CNT_W'(1);

    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (redirect_i) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      stale_d    = outst_d;
    end

    case (state_q)
      S_RUN:   if (stale_d != '0) state_d = S_DRAIN;
      S_DRAIN: if (stale_d == '0) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      stale_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read unless count_q marks it valid.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      data_q[wr_ptr_q] <= imem_resp_data_i;
      pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue. A small imem model answers each
//   accepted request one cycle later, in order, with word_at(addr). Delivered
//   {ins_pc, ins} pairs and accepted request addresses are logged and compared
//   with hand-derived sequences.

module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b1;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit resp_en = 1'b1;

  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (req_ready),
    .imem_resp_valid_i(resp_valid),
    .imem_resp_data_i (resp_data),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .ins_valid_o      (ins_valid),
    .ins_o            (ins),
    .ins_pc_o         (ins_pc),
    .ins_ready_i      (ins_ready)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_resp();
    resp_valid = resp_en && (pend.size() != 0);
    resp_data  = 32'h0;
    if (pend.size() != 0) resp_data = word_at(pend[0]);
  endtask

  // One clock cycle: inputs are set before entry, returns 1 time unit after
  // the next falling edge with imem response inputs already driven.
  task automatic tick();
    bit          fire, rv;
    logic [31:0] addr;
    drive_resp();
    #1;
    fire = req_valid && req_ready;
    addr = req_addr;
    rv   = resp_valid;
    if (ins_valid && ins_ready) begin
      got_pc.push_back(ins_pc);
      got_data.push_back(ins);
    end
    if (fire) req_log.push_back(addr);
    @(posedge clk);
    if (rv) void'(pend.pop_front());
    if (fire) pend.push_back(addr);
    @(negedge clk);
    redirect = 1'b0;
    drive_resp();
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    got_pc.delete();
    got_data.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    pend.delete();
    clear_logs();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_seq(input string tag, input logic [31:0] base, input int n);
    logic [31:0] exp_pc, g_pc, g_data;
    for (int i = 0; i < n; i++) begin
      exp_pc = base + 32'(4 * i);
      g_pc   = (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_DEAD;
      g_data = (i < got_data.size()) ? got_data[i] : 32'hDEAD_DEAD;
      check_val($sformatf("%s_pc%0d", tag, i), g_pc, exp_pc);
      check_val($sformatf("%s_data%0d", tag, i), g_data, word_at(exp_pc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    #1;
    // Reset state
    rst = 1'b1; ins_ready = 1'b1;
    tick(); tick();
    check_val("rst_req_valid", 32'(req_valid), 32'd0);
    check_val("rst_ins_valid", 32'(ins_valid), 32'd0);
    check_val("rst_ins", ins, 32'h0);
    check_val("rst_ins_pc", ins_pc, 32'h0000_3000);

    // 1: streaming from reset, latency 1
    ins_ready = 1'b1; resp_en = 1'b1; req_ready = 1'b1;
    do_reset();
    check_val("t1_first_req_valid", 32'(req_valid), 32'd1);
    check_val("t1_first_req_addr", req_addr, 32'h0000_3000);
    check_val("t1_c0_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    check_val("t1_c1_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    check_val("t1_c2_ins_valid", 32'(ins_valid), 32'd1);
    check_val("t1_c2_ins_pc", ins_pc, 32'h0000_3000);
    check_val("t1_c2_ins", ins, word_at(32'h0000_3000));
    repeat (10) tick();
    for (int i = 0; i < 6; i++)
      check_val($sformatf("t1_req%0d", i),
                (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD, 32'h3000 + 32'(4 * i));
    check_seq("t1", 32'h0000_3000, 8);

    // 2: back-pressure fills FIFO, then drains one per cycle
    ins_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check_val("t2_req_count", 32'(req_log.size()), 32'd4);
    check_val("t2_full_req_valid", 32'(req_valid), 32'd0);
    check_val("t2_full_ins_valid", 32'(ins_valid), 32'd1);
    check_val("t2_full_ins_pc", ins_pc, 32'h0000_3000);
    ins_ready = 1'b1;
    repeat (4) tick();
    check_val("t2_pops_4cyc", 32'(got_pc.size()), 32'd4);
    repeat (12) tick();
    check_seq("t2", 32'h0000_3000, 14);

    // 3: redirect with 2 outstanding, both dropped, drain before refetch
    ins_ready = 1'b1; resp_en = 1'b0; req_ready = 1'b1;
    do_reset();
    tick(); tick();
    req_ready = 1'b0;
    check_val("t3_outstanding_reqs", 32'(req_log.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h0000_4001;
    #1;
    tick();
    resp_en = 1'b1; req_ready = 1'b1;
    #1;
    check_val("t3_drain1_req_valid", 32'(req_valid), 32'd0);
    tick();
    check_val("t3_drain2_req_valid", 32'(req_valid), 32'd0);
    tick();
    check_val("t3_restart_req_valid", 32'(req_valid), 32'd1);
    check_val("t3_restart_req_addr", req_addr, 32'h0000_4000);
    check_val("t3_no_req_in_drain", 32'(req_log.size()), 32'd2);
    repeat (8) tick();
    check_seq("t3", 32'h0000_4000, 4);

    // 4: redirect together with a pop handshake and a response
    ins_ready = 1'b0; resp_en = 1'b1; req_ready = 1'b1;
    do_reset();
    tick(); tick();
    check_val("t4_pre_ins_valid", 32'(ins_valid), 32'd1);
    check_val("t4_pre_ins_pc", ins_pc, 32'h0000_3000);
    redirect = 1'b1; redirect_pc = 32'h0000_6000; ins_ready = 1'b1;
    #1;
    tick();
    check_val("t4_pops", 32'(got_pc.size()), 32'd1);
    check_val("t4_popped_pc", (got_pc.size() > 0) ? got_pc[0] : 32'hDEAD_DEAD, 32'h0000_3000);
    check_val("t4_empty_after", 32'(ins_valid), 32'd0);
    check_val("t4_req_valid", 32'(req_valid), 32'd1);
    check_val("t4_req_addr", req_addr, 32'h0000_6000);
    got_pc.delete(); got_data.delete();
    repeat (8) tick();
    check_seq("t4", 32'h0000_6000, 3);

    // 5: address wrap past 0xFFFF_FFFC
    ins_ready = 1'b1;
    do_reset();
    repeat (5) tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    #1;
    tick();
    got_pc.delete(); got_data.delete();
    repeat (12) tick();
    check_seq("t5", 32'hFFFF_FFF8, 4);

    // 6: reset with FIFO full and nothing outstanding
    ins_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    check_val("t6_full_ins_valid", 32'(ins_valid), 32'd1);
    check_val("t6_full_req_valid", 32'(req_valid), 32'd0);
    rst = 1'b1;
    #1;
    tick();
    check_val("t6_rst_ins_valid", 32'(ins_valid), 32'd0);
    check_val("t6_rst_ins", ins, 32'h0);
    check_val("t6_rst_ins_pc", ins_pc, 32'h0000_3000);
    check_val("t6_rst_req_valid", 32'(req_valid), 32'd0);
    rst = 1'b0;
    pend.delete(); clear_logs();
    #1;
    check_val("t6_restart_req_valid", 32'(req_valid), 32'd1);
    check_val("t6_restart_req_addr", req_addr, 32'h0000_3000);
    ins_ready = 1'b1;
    repeat (8) tick();
    check_seq("t6", 32'h0000_3000, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
